// File: rtl/write_size_adapter.sv
// write_size_adapter
//   Turns byte-addressed, possibly unaligned word/halfword/byte stores into
//   32-bit big-endian word writes with per-byte enables. A store that crosses
//   a word boundary becomes two consecutive beats (IDLE -> SECOND -> IDLE).
//
//   Build option: define WRITE_ADAPTER_SPLIT_EN to enable splitting. Without
//   it there is no SECOND state, and a straddling store is rejected with err.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   byte_wr_addr      byte address of the store's most significant byte
//   transfer_sz       0 = word, 1 = halfword, 2 = byte, 3 = invalid
//   wr_data           right-justified store data
//   wr_en / ready     store handshake (accepted when both high)
//   word_wr_addr      memory word address
//   word_wr_data      write data, byte offset 0 in [31:24]
//   word_wr_be        byte enables, be[3] covers [31:24]
//   word_wr_en        one-cycle write strobe per beat
//   err               one-cycle pulse for a rejected store
module write_size_adapter #(
  parameter int BYTE_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTE_ADDR_WIDTH-1:0] byte_wr_addr,
  input  logic [1:0]                 transfer_sz,
  input  logic [31:0]                wr_data,
  input  logic                       wr_en,
  output logic                       ready,
  output logic [BYTE_ADDR_WIDTH-3:0] word_wr_addr,
  output logic [31:0]                word_wr_data,
  output logic [3:0]                 word_wr_be,
  output logic                       word_wr_en,
  output logic                       err
);
  localparam int WA = BYTE_ADDR_WIDTH - 2;
  localparam logic [1:0] SZ_W = 2'd0, SZ_H = 2'd1, SZ_B = 2'd2;

  logic          accept, sz_ok, straddle;
  logic [1:0]    ofs;
  logic [5:0]    lsh;
  logic [7:0]    ones, mask;
  logic [31:0]   left, win_hi;
  logic [WA-1:0] base_addr;

  logic          nxt_en, nxt_err;
  logic [WA-1:0] nxt_addr;
  logic [31:0]   nxt_data;
  logic [3:0]    nxt_be;

  assign ofs       = byte_wr_addr[1:0];
  assign base_addr = byte_wr_addr[BYTE_ADDR_WIDTH-1:2];
  assign accept    = wr_en && ready;

  // Left-justify the store and build an S-byte enable run starting at byte 0.
  always_comb begin
    sz_ok = 1'b1;
    lsh   = 6'd0;
    ones  = 8'hF0;
    case (transfer_sz)
      SZ_W:    begin lsh = 6'd0;  ones = 8'hF0; end
      SZ_H:    begin lsh = 6'd16; ones = 8'hC0; end
      SZ_B:    begin lsh = 6'd24; ones = 8'h80; end
      default: begin sz_ok = 1'b0; lsh = 6'd0; ones = 8'h00; end
    endcase
  end

  assign left     = wr_data << lsh;
  assign win_hi   = left >> {ofs, 3'b000};
  assign mask     = ones >> ofs;
  // Enables spilling into the low half mean the store crosses into the next word.
  assign straddle = |mask[3:0];

`ifdef WRITE_ADAPTER_SPLIT_EN
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;
  state_t        state, state_nxt;
  logic [WA-1:0] sec_addr;
  logic [31:0]   sec_data, win_lo;
  logic [3:0]    sec_be;

  // Bytes pushed past the end of the first word; offset 0 shifts by 32 -> 0.
  assign win_lo = left << (6'd32 - {1'b0, ofs, 3'b000});
  assign ready  = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && sz_ok && straddle) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Second-beat holding registers; word address wraps at the top of memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_addr <= '0;
      sec_data <= '0;
      sec_be   <= '0;
    end else if (accept) begin
      sec_addr <= base_addr + WA'(1);
      sec_data <= win_lo;
      sec_be   <= mask[3:0];
    end
  end

  always_comb begin
    nxt_en   = 1'b0;
    nxt_err  = 1'b0;
    nxt_addr = word_wr_addr;
    nxt_data = '0;
    nxt_be   = '0;
    if (state == SECOND) begin
      nxt_en   = 1'b1;
      nxt_addr = sec_addr;
      nxt_data = sec_data;
      nxt_be   = sec_be;
    end else if (accept) begin
      if (!sz_ok) begin
        nxt_err = 1'b1;
      end else begin
        nxt_en   = 1'b1;
        nxt_addr = base_addr;
        nxt_data = win_hi;
        nxt_be   = mask[7:4];
      end
    end
  end
`else
  assign ready = !rst;

  always_comb begin
    nxt_en   = 1'b0;
    nxt_err  = 1'b0;
    nxt_addr = word_wr_addr;
    nxt_data = '0;
    nxt_be   = '0;
    if (accept) begin
      if (!sz_ok || straddle) begin
        nxt_err = 1'b1;
      end else begin
        nxt_en   = 1'b1;
        nxt_addr = base_addr;
        nxt_data = win_hi;
        nxt_be   = mask[7:4];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      word_wr_addr <= '0;
      word_wr_data <= '0;
      word_wr_be   <= '0;
      word_wr_en   <= 1'b0;
      err          <= 1'b0;
    end else begin
      word_wr_addr <= nxt_addr;
      word_wr_data <= nxt_data;
      word_wr_be   <= nxt_be;
      word_wr_en   <= nxt_en;
      err          <= nxt_err;
    end
  end

endmodule

// File: tb/tb_write_size_adapter.sv
module tb_write_size_adapter;
  localparam int AW = 12;
`ifdef WRITE_ADAPTER_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] byte_wr_addr;
  logic [1:0]    transfer_sz;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          ready;
  logic [AW-3:0] word_wr_addr;
  logic [31:0]   word_wr_data;
  logic [3:0]    word_wr_be;
  logic          word_wr_en;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_size_adapter #(.BYTE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .byte_wr_addr(byte_wr_addr), .transfer_sz(transfer_sz),
    .wr_data(wr_data), .wr_en(wr_en), .ready(ready), .word_wr_addr(word_wr_addr),
    .word_wr_data(word_wr_data), .word_wr_be(word_wr_be), .word_wr_en(word_wr_en),
    .err(err)
  );

  // Reference: walk the store byte by byte (big-endian), group by word.
  int            m_n;
  logic          m_err;
  logic [AW-3:0] m_addr[2];
  logic [31:0]   m_data[2];
  logic [3:0]    m_be[2];

  function automatic void model(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
    int s, lane;
    logic [AW-1:0] ba;
    logic [7:0] b;
    m_n = 0;
    m_err = 1'b0;
    for (int k = 0; k < 2; k++) begin m_addr[k] = '0; m_data[k] = '0; m_be[k] = '0; end
    case (sz)
      2'd0: s = 4;
      2'd1: s = 2;
      2'd2: s = 1;
      default: s = 0;
    endcase
    if (s == 0) begin m_err = 1'b1; return; end
    for (int i = 0; i < s; i++) begin
      ba = a + AW'(i);
      b  = 8'(d >> (8 * (s - 1 - i)));
      if (m_n == 0 || ba[AW-1:2] != m_addr[m_n-1]) begin
        m_addr[m_n] = ba[AW-1:2];
        m_n++;
      end
      lane = int'(ba[1:0]);
      m_data[m_n-1][31-8*lane -: 8] = b;
      m_be[m_n-1][3-lane] = 1'b1;
    end
    if (m_n == 2 && !SPLIT) begin m_n = 0; m_err = 1'b1; end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
    byte_wr_addr = a; transfer_sz = sz; wr_data = d; wr_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_store(12'h010, 2'd0, 32'hCAFEF00D);
    tick();
    tick();
    n_cmp++;
    if ({word_wr_en, err, word_wr_be, word_wr_addr, word_wr_data} !== '0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: en=%b err=%b be=%b a=%h d=%h ready=%b, want all 0",
               word_wr_en, err, word_wr_be, word_wr_addr, word_wr_data, ready);
    end
    rst = 1'b0; wr_en = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: ready=%b want 1", ready); end
    tick();
    n_cmp++;
    if (word_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_drop: en=%b want 0", word_wr_en); end
  endtask

  task automatic test_aligned_word();
    set_store(12'h010, 2'd0, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (word_wr_en !== 1'b1 || word_wr_addr !== 10'h004 || word_wr_data !== 32'hDEADBEEF ||
        word_wr_be !== 4'b1111 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL aligned_word: en=%b a=%h d=%h be=%b rdy=%b, want 1 004 deadbeef 1111 1",
               word_wr_en, word_wr_addr, word_wr_data, word_wr_be, ready);
    end
    tick();
    n_cmp++;
    if (word_wr_en !== 1'b0) begin n_bad++; $display("FAIL aligned_single: en=%b want 0", word_wr_en); end
  endtask

  task automatic test_byte_off3();
    set_store(12'h007, 2'd2, 32'h000000A5);
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if (word_wr_en !== 1'b1 || word_wr_addr !== 10'h001 || word_wr_data !== 32'h000000A5 ||
        word_wr_be !== 4'b0001) begin
      n_bad++;
      $display("FAIL byte_off3: en=%b a=%h d=%h be=%b, want 1 001 000000a5 0001",
               word_wr_en, word_wr_addr, word_wr_data, word_wr_be);
    end
    tick();
  endtask

  task automatic test_straddle(input string nm, input logic [AW-1:0] a, input logic [1:0] sz,
                               input logic [31:0] d, input logic [9:0] a1, input logic [31:0] d1,
                               input logic [3:0] b1, input logic [9:0] a2, input logic [31:0] d2,
                               input logic [3:0] b2);
    set_store(a, sz, d);
    tick();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (SPLIT) begin
      if (word_wr_en !== 1'b1 || word_wr_addr !== a1 || word_wr_data !== d1 || word_wr_be !== b1 ||
          ready !== 1'b0 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_beat1: en=%b a=%h d=%h be=%b rdy=%b err=%b, want 1 %h %h %b 0 0", nm,
                 word_wr_en, word_wr_addr, word_wr_data, word_wr_be, ready, err, a1, d1, b1);
      end
      tick();
      n_cmp++;
      if (word_wr_en !== 1'b1 || word_wr_addr !== a2 || word_wr_data !== d2 || word_wr_be !== b2 ||
          ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_beat2: en=%b a=%h d=%h be=%b rdy=%b, want 1 %h %h %b 1", nm,
                 word_wr_en, word_wr_addr, word_wr_data, word_wr_be, ready, a2, d2, b2);
      end
    end else begin
      if (word_wr_en !== 1'b0 || err !== 1'b1 || ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_reject: en=%b err=%b rdy=%b, want 0 1 1", nm, word_wr_en, err, ready);
      end
    end
    tick();
    n_cmp++;
    if (word_wr_en !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_after: en=%b err=%b, want 0 0", nm, word_wr_en, err);
    end
  endtask

  task automatic test_invalid_back_to_back();
    logic [3:0] exp_be;
    set_store(12'h040, 2'd3, 32'h12345678);
    tick();
    n_cmp++;
    if (err !== 1'b1 || word_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_sz: err=%b en=%b, want 1 0", err, word_wr_en);
    end
    for (int k = 0; k < 4; k++) begin
      set_store(AW'(12'h020 + k), 2'd2, 32'(8'h50 + k));
      tick();
      exp_be = 4'b1000 >> k;
      n_cmp++;
      if (word_wr_en !== 1'b1 || err !== 1'b0 || word_wr_addr !== 10'h008 || word_wr_be !== exp_be ||
          word_wr_data !== (32'(8'h50 + k) << (8 * (3 - k)))) begin
        n_bad++;
        $display("FAIL b2b_%0d: en=%b err=%b a=%h d=%h be=%b, want 1 0 008 be=%b", k,
                 word_wr_en, err, word_wr_addr, word_wr_data, word_wr_be, exp_be);
      end
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_second();
    set_store(12'h00B, 2'd1, 32'h00001234);
    tick();
    wr_en = 1'b0;
    rst = 1'b1;
    n_cmp++;
    if (SPLIT ? (word_wr_en !== 1'b1) : (err !== 1'b1 || word_wr_en !== 1'b0)) begin
      n_bad++;
      $display("FAIL rst2_first: en=%b err=%b split=%b", word_wr_en, err, SPLIT);
    end
    tick();
    n_cmp++;
    if ({word_wr_en, err, word_wr_be, word_wr_addr, word_wr_data} !== '0) begin
      n_bad++;
      $display("FAIL rst2_zero: en=%b err=%b be=%b a=%h d=%h, want all 0",
               word_wr_en, err, word_wr_be, word_wr_addr, word_wr_data);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL rst2_ready: ready=%b want 1", ready); end
    tick();
    n_cmp++;
    if (word_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst2_nobeat: en=%b want 0", word_wr_en); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [1:0] sz;
    logic [31:0] d;
    for (int it = 0; it < 400; it++) begin
      a  = AW'($urandom_range(0, 4095));
      sz = 2'($urandom_range(0, 3));
      d  = $urandom;
      model(a, sz, d);
      set_store(a, sz, d);
      #1;
      n_cmp++;
      if (ready !== 1'b1) begin n_bad++; $display("FAIL rand_ready it=%0d: ready=%b want 1", it, ready); end
      tick();
      // While busy, keep a different store asserted; it must be ignored.
      if (m_n == 2) set_store(AW'($urandom), 2'($urandom), $urandom);
      else wr_en = 1'b0;
      n_cmp++;
      if (m_err) begin
        if (word_wr_en !== 1'b0 || err !== 1'b1) begin
          n_bad++;
          $display("FAIL rand_err it=%0d a=%h sz=%0d: en=%b err=%b, want 0 1", it, a, sz, word_wr_en, err);
        end
      end else if (word_wr_en !== 1'b1 || err !== 1'b0 || word_wr_addr !== m_addr[0] ||
                   word_wr_data !== m_data[0] || word_wr_be !== m_be[0]) begin
        n_bad++;
        $display("FAIL rand_beat1 it=%0d a=%h sz=%0d: en=%b err=%b a=%h d=%h be=%b, want a=%h d=%h be=%b",
                 it, a, sz, word_wr_en, err, word_wr_addr, word_wr_data, word_wr_be,
                 m_addr[0], m_data[0], m_be[0]);
      end
      if (m_n == 2) begin
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL rand_busy it=%0d: ready=%b want 0", it, ready); end
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (word_wr_en !== 1'b1 || err !== 1'b0 || word_wr_addr !== m_addr[1] ||
            word_wr_data !== m_data[1] || word_wr_be !== m_be[1]) begin
          n_bad++;
          $display("FAIL rand_beat2 it=%0d a=%h sz=%0d: en=%b a=%h d=%h be=%b, want a=%h d=%h be=%b",
                   it, a, sz, word_wr_en, word_wr_addr, word_wr_data, word_wr_be,
                   m_addr[1], m_data[1], m_be[1]);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if (word_wr_en !== 1'b0 || err !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_idle it=%0d: en=%b err=%b, want 0 0", it, word_wr_en, err);
        end
      end
    end
    wr_en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; byte_wr_addr = '0; transfer_sz = '0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_aligned_word();
    test_byte_off3();
    test_straddle("half_straddle", 12'h00B, 2'd1, 32'h00001234,
                  10'h002, 32'h00000012, 4'b0001, 10'h003, 32'h34000000, 4'b1000);
    test_straddle("top_word", 12'hFFE, 2'd0, 32'h11223344,
                  10'h3FF, 32'h00001122, 4'b0011, 10'h000, 32'h33440000, 4'b1100);
    test_invalid_back_to_back();
    test_reset_in_second();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_size_adapter.md
# write_size_adapter

Write-side counterpart of the packet filter's variable-size read path: accepts byte-addressed, possibly unaligned word/halfword/byte stores and turns them into one or two 32-bit word writes with per-byte enables into big-endian packet RAM. Sits between the store/forwarding logic and the 32-bit write port of the packet memory. Stores that straddle a word boundary are split into two consecutive memory beats by a small state machine; aligned or in-word stores take a single beat at full throughput.

## Interface
- BYTE_ADDR_WIDTH, default 12, byte address width; memory word address is BYTE_ADDR_WIDTH-2 bits.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_wr_addr  in  BYTE_ADDR_WIDTH  byte address of the store's first (most significant) byte.
- transfer_sz  in  2  `BPF_W (0) = 4 bytes, `BPF_H (1) = 2, `BPF_B (2) = 1; 3 is invalid.
- wr_data  in  32  store data, right-justified (a byte occupies [7:0], a halfword [15:0]).
- wr_en  in  1  store request; accepted when wr_en && ready.
- ready  out  1  adapter can accept a store this cycle.
- word_wr_addr  out  BYTE_ADDR_WIDTH-2  memory word address.
- word_wr_data  out  32  memory write data; byte offset 0 is bits [31:24].
- word_wr_be  out  4  byte enables; be[3] covers [31:24], be[0] covers [7:0].
- word_wr_en  out  1  memory write strobe.
- err  out  1  one-cycle pulse on a rejected store.

## Operation
- States: IDLE, SECOND. ready = (state == IDLE) && !rst (combinational).
- On acceptance, with o = byte_wr_addr[1:0] and S = size in bytes: left = wr_data << 8*(4-S); win[63:0] = {left, 32'h0} >> 8*o; mask[7:0] = ({S ones, zeros}) >> o.
- Beat 1: word_wr_addr = byte_wr_addr[BYTE_ADDR_WIDTH-1:2], data = win[63:32], be = mask[7:4].
- If mask[3:0] != 0 (straddle: o+S > 4): go to SECOND, latching addr+1, win[31:0], mask[3:0]; beat 2 issued from SECOND, then return to IDLE.
- Address +1 wraps modulo 2^(BYTE_ADDR_WIDTH-2) (top word -> word 0).
- Bytes not enabled must not be written; word_wr_data bits outside be are don't-care but driven to 0.
- transfer_sz == 3: no memory write, err pulses, state stays IDLE.
- Beats are never merged; each beat asserts word_wr_en for exactly one cycle.

## Timing
- All memory-side outputs and err are registered; reset value 0 for word_wr_addr, word_wr_data, word_wr_be, word_wr_en, err; state resets to IDLE.
- Latency: store accepted at edge N -> beat 1 visible in cycle after N; beat 2 (if any) one cycle later.
- Throughput: one non-straddling store per cycle; a straddling store costs two cycles (ready low in SECOND).
- wr_en while ready is low is ignored (not queued); requester must hold the store.
- rst asserted in SECOND: pending beat 2 discarded, no memory write in the following cycle, state IDLE.
- rst and wr_en in the same cycle: reset wins, store dropped.

## Configuration
- WRITE_ADAPTER_SPLIT_EN defined: straddling stores split into two beats as above.
- Not defined: SECOND state is absent; ready = !rst; a straddling store performs no memory write and pulses err; in-word stores behave identically.

## Test plan
- Aligned word: addr 0x010, sz W, data 0xDEADBEEF -> one beat, word addr 0x004, data 0xDEADBEEF, be 4'b1111, ready never drops.
- Byte at offset 3: addr 0x007, sz B, data 0x000000A5 -> word addr 0x001, data 0x000000A5, be 4'b0001.
- Straddling halfword (split enabled): addr 0x00B, sz H, data 0x00001234 -> beat 1 addr 0x002, data 0x00000012, be 0001; beat 2 addr 0x003, data 0x34000000, be 1000; ready low one cycle.
- Straddling word at top word: addr 0xFFE, sz W, data 0x11223344 -> beat 1 addr 0x3FF, be 0011, data 0x00001122; beat 2 addr 0x000, be 1100, data 0x33440000.
- Invalid size and back-to-back: sz 3 -> err pulse, no word_wr_en; then four consecutive aligned byte stores to 0x020..0x023 -> four beats on four consecutive cycles, be 1000,0100,0010,0001.
- Reset in SECOND: straddling store accepted, rst asserted next cycle -> no beat 2, all outputs 0, ready high after rst drops; without WRITE_ADAPTER_SPLIT_EN the same store yields err and no write.
